// File: rtl/memory_access.sv
// LEGv8 memory-stage load/store unit: one req/ack access per instruction, stall while pending,
// bounded wait converts a hung memory into an err_M pulse. Optional macro: MEM_ALIGN_CHECK_EN.
module memory_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_M,
  input  logic        memWrite_M,
  input  logic [63:0] aluResult_M,
  input  logic [63:0] writeData_M,
  output logic [63:0] readData_M,
  output logic        stall_M,
  output logic        err_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q;
  logic       req_any, req_both, misalign;

  assign req_any  = memRead_M | memWrite_M;
  assign req_both = memRead_M & memWrite_M;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (aluResult_M[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_both)     state_d = ERR;
        else if (req_any) state_d = misalign ? ERR : ACCESS;
      end
      // ack takes priority over an expiring counter
      ACCESS: begin
        if (mem_ack)                state_d = DONE;
        else if (cnt_q == CNT_LAST) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall_M = ((state_q == IDLE) && req_any) || (state_q == ACCESS);
  assign err_M   = (state_q == ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      readData_M <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (state_d == ACCESS) begin
            mem_req   <= 1'b1;
            mem_we    <= memWrite_M;
            mem_addr  <= aluResult_M;
            mem_wdata <= writeData_M;
            cnt_q     <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) readData_M <= mem_rdata;
          end else if (cnt_q == CNT_LAST) begin
            mem_req <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
      // error path (timeout, illegal or misaligned) leaves no stale load data behind
      if (state_d == ERR) readData_M <= '0;
    end
  end

endmodule
